// File: rtl/hold_tx_pkg.sv
// -----------------------------------------------------------------------------
// hold_tx_pkg
// Shared types and constants for the active-low hold transmitter.
//   state_t  : FSM states (GUARD is only reachable when HOLD_TX_GUARD_EN is
//              defined at compile time).
//   tick_w() : prescaler counter width for a given cycles-per-second value.
//   TICK_W   : prescaler width for the default 24 MHz clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package hold_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      GUARD = 2'd2
   } state_t;

   // A one-cycle tick period still needs a 1-bit counter to be legal.
   function automatic int tick_w(input int cyc);
      return (cyc > 1) ? $clog2(cyc) : 1;
   endfunction

   localparam int TICK_CYC_DEF = 24000000;
   localparam int TICK_W       = tick_w(TICK_CYC_DEF);

endpackage

// File: rtl/hold_tx_if.sv
// -----------------------------------------------------------------------------
// hold_tx_if
// Control-side handshake and line bundle of the hold transmitter.
//   start    : request pulse (master -> slave)
//   hold_sec : hold length in seconds, sampled with start (master -> slave)
//   abort    : terminate an active hold (master -> slave)
//   ledx_o   : active-low hold line, 1 = released (slave -> master)
//   busy     : transmitter occupied (slave -> master)
//   done     : one-cycle pulse on normal completion (slave -> master)
//   aborted  : one-cycle pulse on aborted completion (slave -> master)
// Modports: master = control logic, slave = hold_tx.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hold_tx_if #(
   parameter int SEC_W = 4
) ();

   logic             start;
   logic [SEC_W-1:0] hold_sec;
   logic             abort;
   logic             ledx_o;
   logic             busy;
   logic             done;
   logic             aborted;

   modport master (
      output start, hold_sec, abort,
      input  ledx_o, busy, done, aborted
   );

   modport slave (
      input  start, hold_sec, abort,
      output ledx_o, busy, done, aborted
   );

endinterface

// File: rtl/hold_tx_sec_tick.sv
// -----------------------------------------------------------------------------
// sec_tick
// Cycle prescaler: counts 0..TICK_CYC-1 while en is high and emits a one-cycle
// tick at TICK_CYC-1, wrapping to 0. clr (synchronous) forces the count to 0.
// Build option HOLD_TX_GUARD_EN adds pre_tick, asserted one count earlier
// (TICK_CYC-2), used to end the guard interval one cycle ahead of a full tick.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous count clear
//   en       : count enable
//   tick     : one-cycle pulse at count TICK_CYC-1
//   pre_tick : (HOLD_TX_GUARD_EN only) pulse at count TICK_CYC-2
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sec_tick
   import hold_tx_pkg::*;
#(
   parameter int TICK_CYC = 24000000,
   parameter int TICK_W   = tick_w(TICK_CYC)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
`ifdef HOLD_TX_GUARD_EN
   ,
   output logic pre_tick
`endif
);

   localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_CYC - 1);

   logic [TICK_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         if (cnt_q == LAST) cnt_q <= '0;
         else               cnt_q <= cnt_q + TICK_W'(1);
      end
   end

   assign tick = en && (cnt_q == LAST);

`ifdef HOLD_TX_GUARD_EN
   localparam bit                HAS_PRE = (TICK_CYC > 1);
   localparam logic [TICK_W-1:0] PRE     = TICK_W'((TICK_CYC > 1) ? TICK_CYC - 2 : 0);

   assign pre_tick = HAS_PRE && en && (cnt_q == PRE);
`endif

endmodule

// File: rtl/hold_tx.sv
// -----------------------------------------------------------------------------
// hold_tx
// Transmit side of the active-low hold protocol. An accepted start drives
// ledx_o low for hold_sec whole seconds (hold_sec * TICK_CYC cycles), then
// releases the line and pulses done. abort ends a hold early and pulses
// aborted instead. start is only honoured in IDLE with abort low and a
// non-zero hold_sec.
// Build option HOLD_TX_GUARD_EN: after release the block stays busy in GUARD
// so that the line is seen high for one full tick (TICK_CYC cycles, counting
// the IDLE cycle in which the next start is sampled) before another hold.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : hold_tx_if.slave (start, hold_sec, abort / ledx_o, busy, done,
//         aborted)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hold_tx
   import hold_tx_pkg::*;
#(
   parameter int TICK_CYC = 24000000,
   parameter int SEC_W    = 4
) (
   input  logic        clk,
   input  logic        rst,
   hold_tx_if.slave    bus
);

   localparam int TW = tick_w(TICK_CYC);

`ifdef HOLD_TX_GUARD_EN
   // A one-cycle tick leaves no room for a guard beyond the IDLE cycle itself.
   localparam state_t POST_HOLD = (TICK_CYC > 1) ? GUARD : IDLE;
`else
   localparam state_t POST_HOLD = IDLE;
`endif

   state_t           state_q;
   state_t           state_n;
   logic [SEC_W-1:0] sec_lat;
   logic [SEC_W-1:0] sec_cnt_q;
   logic             accept;
   logic             tick;
   logic             last_sec;
   logic             hold_end;
   logic             pre_clr;
   logic             pre_en;
   logic             done_q;
   logic             aborted_q;

   assign accept   = (state_q == IDLE) && bus.start && !bus.abort && (bus.hold_sec != '0);
   // Seconds counter counts completed seconds; the hold ends on the wrap that
   // completes the last one.
   assign last_sec = ((sec_cnt_q + SEC_W'(1)) == sec_lat);
   assign hold_end = (state_q == HOLD) && tick && last_sec;

   // Prescaler starts from 0 on every HOLD entry and again on every HOLD exit,
   // so GUARD timing is independent of where an abort landed.
   assign pre_clr = (state_q == IDLE) || ((state_q == HOLD) && (state_n != HOLD));
   assign pre_en  = (state_q != IDLE);

`ifdef HOLD_TX_GUARD_EN
   logic guard_end;

   sec_tick #(
      .TICK_CYC (TICK_CYC),
      .TICK_W   (TW)
   ) u_sec_tick (
      .clk      (clk),
      .rst      (rst),
      .clr      (pre_clr),
      .en       (pre_en),
      .tick     (tick),
      .pre_tick (guard_end)
   );
`else
   sec_tick #(
      .TICK_CYC (TICK_CYC),
      .TICK_W   (TW)
   ) u_sec_tick (
      .clk      (clk),
      .rst      (rst),
      .clr      (pre_clr),
      .en       (pre_en),
      .tick     (tick)
   );
`endif

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   // ---- next-state logic ----
   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE:  if (accept) state_n = HOLD;
         // abort has priority, but both exits leave HOLD on the same edge.
         HOLD:  if (bus.abort || hold_end) state_n = POST_HOLD;
`ifdef HOLD_TX_GUARD_EN
         GUARD: if (guard_end) state_n = IDLE;
`else
         GUARD: state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
   end

   // ---- outputs ----
   always_comb begin
      bus.ledx_o  = (state_q != HOLD);
      bus.busy    = (state_q != IDLE);
      bus.done    = done_q;
      bus.aborted = aborted_q;
   end

   // ---- completion pulses, counters, request latch ----
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         sec_cnt_q <= '0;
      end else begin
         done_q    <= hold_end && !bus.abort;
         aborted_q <= (state_q == HOLD) && bus.abort;
         if (state_q != HOLD) sec_cnt_q <= '0;
         else if (tick)       sec_cnt_q <= sec_cnt_q + SEC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) sec_lat <= bus.hold_sec;
   end

endmodule

// File: tb/tb_hold_tx.sv
// -----------------------------------------------------------------------------
// tb_hold_tx
// Self-checking bench for hold_tx with TICK_CYC=10, SEC_W=4. Each scenario
// pushes the expected hold (low length and completion kind) to exp_q; a
// negedge monitor records every observed hold into obs_q, and the scenario
// tasks compare the two. Honors HOLD_TX_GUARD_EN for the release-time busy
// level and the back-to-back gap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hold_tx;

   localparam int TICK = 10;
   localparam int SW   = 4;
`ifdef HOLD_TX_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif
   localparam logic EXP_BUSY_REL = GUARD_ON;
   localparam int   EXP_GAP      = GUARD_ON ? TICK : 1;

   // kind: 0 = done pulse, 1 = aborted pulse, 2 = no pulse, 3 = both
   typedef struct {
      int len;
      int kind;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hold_tx_if #(.SEC_W(SW)) bus ();

   hold_tx #(
      .TICK_CYC (TICK),
      .SEC_W    (SW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   int   obs_idx   = 0;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   spur_cnt  = 0;
   bit   mon_en    = 1'b0;
   int   low_run   = 0;
   logic prev_ledx = 1'b1;

   function automatic int kind_of(input logic d, input logic a);
      if (d === 1'b1 && a === 1'b1) return 3;
      if (d === 1'b1)               return 0;
      if (a === 1'b1)               return 1;
      return 2;
   endfunction

   // Monitor: measures every low run of ledx_o and the pulse seen in the first
   // released cycle; any pulse elsewhere is counted as spurious.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.ledx_o === 1'b1 && prev_ledx === 1'b0) begin
            obs_q.push_back('{low_run, kind_of(bus.done, bus.aborted)});
            low_run = 0;
         end else begin
            if (bus.done === 1'b1 || bus.aborted === 1'b1) spur_cnt++;
            if (bus.ledx_o === 1'b0) low_run++;
         end
         prev_ledx = bus.ledx_o;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits (from a negedge) while ledx_o is low, bounded; returns low cycles seen.
   task automatic wait_release(output int n);
      n = 0;
      while (bus.ledx_o === 1'b0 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.hold_sec = '0;
      cyc(3);
      @(negedge clk);
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL reset_ledx: got %b want 1", bus.ledx_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.aborted !== 1'b0) $display("FAIL reset_aborted: got %b want 0", bus.aborted);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      cyc(2);
   endtask

   task automatic test_hold4();
      int   n;
      int   busy_bad;
      ev_t  o;
      ev_t  e;
      bus.hold_sec = 4'd4;
      bus.start    = 1'b1;
      exp_q.push_back('{40, 0});
      cyc(1);
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      @(negedge clk);
      total_cnt++;
      if (bus.ledx_o !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL hold4_start: ledx %b busy %b want 0 1", bus.ledx_o, bus.busy);
      else pass_cnt++;
      busy_bad = 0;
      n = 0;
      while (bus.ledx_o === 1'b0 && n < 200) begin
         if (bus.busy !== 1'b1) busy_bad++;
         n++;
         @(negedge clk);
      end
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL hold4_timeout: ledx %b after %0d cycles", bus.ledx_o, n);
      else pass_cnt++;
      total_cnt++;
      if (busy_bad != 0) $display("FAIL hold4_busy_low: %0d cycles busy low during hold, want 0", busy_bad);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== EXP_BUSY_REL) $display("FAIL hold4_busy_rel: got %b want %b", bus.busy, EXP_BUSY_REL);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b1) $display("FAIL hold4_done: got %b want 1", bus.done);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (obs_idx >= obs_q.size()) $display("FAIL hold4_sb: no hold observed");
      else begin
         o = obs_q[obs_idx];
         obs_idx++;
         e = exp_q.pop_front();
         if (o.len !== e.len || o.kind !== e.kind)
            $display("FAIL hold4_sb: got len %0d kind %0d want len %0d kind %0d", o.len, o.kind, e.len, e.kind);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL hold4_done_width: got %b want 0", bus.done);
      else pass_cnt++;
      cyc(15);
   endtask

   task automatic test_zero();
      int bad;
      bus.hold_sec = '0;
      bus.start    = 1'b1;
      cyc(1);
      bus.start    = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.ledx_o !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL zero_ignored: %0d disturbed cycles, want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (obs_q.size() != obs_idx) $display("FAIL zero_no_hold: %0d holds observed, want 0", obs_q.size() - obs_idx);
      else pass_cnt++;
      cyc(2);
   endtask

   task automatic test_abort(input int c);
      ev_t o;
      ev_t e;
      bus.hold_sec = 4'd3;
      bus.start    = 1'b1;
      exp_q.push_back('{c + 1, 1});
      cyc(1);
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      cyc(c);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.ledx_o !== 1'b1 || bus.aborted !== 1'b1 || bus.done !== 1'b0)
         $display("FAIL abort%0d_release: ledx %b aborted %b done %b want 1 1 0", c, bus.ledx_o, bus.aborted, bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== EXP_BUSY_REL) $display("FAIL abort%0d_busy: got %b want %b", c, bus.busy, EXP_BUSY_REL);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (obs_idx >= obs_q.size()) $display("FAIL abort%0d_sb: no hold observed", c);
      else begin
         o = obs_q[obs_idx];
         obs_idx++;
         e = exp_q.pop_front();
         if (o.len !== e.len || o.kind !== e.kind)
            $display("FAIL abort%0d_sb: got len %0d kind %0d want len %0d kind %0d", c, o.len, o.kind, e.len, e.kind);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if (bus.aborted !== 1'b0) $display("FAIL abort%0d_pulse_width: got %b want 0", c, bus.aborted);
      else pass_cnt++;
      cyc(15);
   endtask

   task automatic test_ignore();
      int  n;
      int  bad;
      ev_t o;
      ev_t e;
      bus.hold_sec = 4'd2;
      bus.start    = 1'b1;
      exp_q.push_back('{20, 0});
      cyc(1);
      bus.start    = 1'b0;
      cyc(5);
      bus.hold_sec = 4'd9;
      bus.start    = 1'b1;
      cyc(1);
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      @(negedge clk);
      total_cnt++;
      if (bus.ledx_o !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL ignore_mid: ledx %b busy %b want 0 1", bus.ledx_o, bus.busy);
      else pass_cnt++;
      wait_release(n);
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL ignore_timeout: ledx %b after %0d cycles", bus.ledx_o, n);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (obs_idx >= obs_q.size()) $display("FAIL ignore_sb: no hold observed");
      else begin
         o = obs_q[obs_idx];
         obs_idx++;
         e = exp_q.pop_front();
         if (o.len !== e.len || o.kind !== e.kind)
            $display("FAIL ignore_sb: got len %0d kind %0d want len %0d kind %0d", o.len, o.kind, e.len, e.kind);
         else pass_cnt++;
      end
      cyc(15);
      bus.hold_sec = 4'd3;
      bus.start    = 1'b1;
      bus.abort    = 1'b1;
      cyc(1);
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.hold_sec = '0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ledx_o !== 1'b1 || bus.busy !== 1'b0) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL start_abort_idle: %0d disturbed cycles, want 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (obs_q.size() != obs_idx) $display("FAIL start_abort_no_hold: %0d holds observed, want 0", obs_q.size() - obs_idx);
      else pass_cnt++;
      cyc(1);
   endtask

   task automatic test_rst_mid();
      int  n;
      ev_t o;
      ev_t e;
      bus.hold_sec = 4'd3;
      bus.start    = 1'b1;
      exp_q.push_back('{8, 2});
      cyc(1);
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      cyc(7);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.ledx_o !== 1'b1 || bus.busy !== 1'b0)
         $display("FAIL rst_mid_state: ledx %b busy %b want 1 0", bus.ledx_o, bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0 || bus.aborted !== 1'b0)
         $display("FAIL rst_mid_pulse: done %b aborted %b want 0 0", bus.done, bus.aborted);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (obs_idx >= obs_q.size()) $display("FAIL rst_mid_sb: no hold observed");
      else begin
         o = obs_q[obs_idx];
         obs_idx++;
         e = exp_q.pop_front();
         if (o.len !== e.len || o.kind !== e.kind)
            $display("FAIL rst_mid_sb: got len %0d kind %0d want len %0d kind %0d", o.len, o.kind, e.len, e.kind);
         else pass_cnt++;
      end
      cyc(2);
      bus.hold_sec = 4'd1;
      bus.start    = 1'b1;
      exp_q.push_back('{10, 0});
      cyc(1);
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      @(negedge clk);
      wait_release(n);
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL rst_after_timeout: ledx %b after %0d cycles", bus.ledx_o, n);
      else pass_cnt++;
      #2;
      total_cnt++;
      if (obs_idx >= obs_q.size()) $display("FAIL rst_after_sb: no hold observed");
      else begin
         o = obs_q[obs_idx];
         obs_idx++;
         e = exp_q.pop_front();
         if (o.len !== e.len || o.kind !== e.kind)
            $display("FAIL rst_after_sb: got len %0d kind %0d want len %0d kind %0d", o.len, o.kind, e.len, e.kind);
         else pass_cnt++;
      end
      cyc(15);
   endtask

   task automatic test_back_to_back();
      int  n;
      int  gap;
      ev_t o;
      ev_t e;
      bus.hold_sec = 4'd1;
      bus.start    = 1'b1;
      exp_q.push_back('{10, 0});
      exp_q.push_back('{10, 0});
      cyc(1);
      @(negedge clk);
      wait_release(n);
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL b2b_first_timeout: ledx %b after %0d cycles", bus.ledx_o, n);
      else pass_cnt++;
      gap = 0;
      while (bus.ledx_o === 1'b1 && gap < 40) begin
         gap++;
         @(negedge clk);
      end
      bus.start    = 1'b0;
      bus.hold_sec = '0;
      total_cnt++;
      if (gap != EXP_GAP) $display("FAIL b2b_gap: got %0d high cycles want %0d", gap, EXP_GAP);
      else pass_cnt++;
      wait_release(n);
      total_cnt++;
      if (bus.ledx_o !== 1'b1) $display("FAIL b2b_second_timeout: ledx %b after %0d cycles", bus.ledx_o, n);
      else pass_cnt++;
      #2;
      for (int i = 0; i < 2; i++) begin
         total_cnt++;
         if (obs_idx >= obs_q.size()) $display("FAIL b2b_sb%0d: no hold observed", i);
         else begin
            o = obs_q[obs_idx];
            obs_idx++;
            e = exp_q.pop_front();
            if (o.len !== e.len || o.kind !== e.kind)
               $display("FAIL b2b_sb%0d: got len %0d kind %0d want len %0d kind %0d", i, o.len, o.kind, e.len, e.kind);
            else pass_cnt++;
         end
      end
      cyc(15);
   endtask

   task automatic test_final();
      total_cnt++;
      if (spur_cnt != 0) $display("FAIL spurious_pulses: got %0d want 0", spur_cnt);
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0 || obs_q.size() != obs_idx)
         $display("FAIL sb_leftover: expected left %0d observed left %0d want 0 0", exp_q.size(), obs_q.size() - obs_idx);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_hold4();
      test_zero();
      test_abort(15);
      test_abort(29);
      test_ignore();
      test_rst_mid();
      test_back_to_back();
      test_final();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
